pipelined_processing_element: RTL and testbench

PIPELINED_PROCESSING_ELEMENT -- requirements
Module: pipelined_processing_element

---
 rtl/pipelined_processing_element.sv | 140 ++++++++++++++
 tb/tb_pipelined_processing_element.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_processing_element.sv
// Two-stage multiply-accumulate processing element for a systolic array.
// Double-buffered weight, optional output clamp, activation forwarding.
module pipelined_processing_element #(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 32,
   parameter int SAT_MIN = -128,
   parameter int SAT_MAX = 127
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     in_valid,
   input  logic                     load_weight,
   input  logic                     swap_weight,
   input  logic                     clamp_en,
   input  logic signed [DATA_W-1:0] input_data,
   input  logic signed [DATA_W-1:0] weight_data,
   input  logic signed [ACC_W-1:0]  partial_in,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     data_out_valid,
   output logic signed [ACC_W-1:0]  partial_out,
   output logic                     out_valid,
   output logic                     saturated,
   output logic [31:0]              mac_operations
);

   localparam int PW = 2 * DATA_W;
   localparam int SW = ACC_W + 1;

   localparam logic signed [SW-1:0] SMAX = SW'(SAT_MAX);
   localparam logic signed [SW-1:0] SMIN = SW'(SAT_MIN);

   if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("ACC_W must be at least 2*DATA_W");
   end

   if (SAT_MIN >= SAT_MAX) begin : g_bad_sat
      $error("SAT_MIN must be below SAT_MAX");
   end

   logic signed [DATA_W-1:0] shadow_w;
   logic signed [DATA_W-1:0] active_w;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  pin;
   logic                     v1;

   logic signed [PW-1:0]     mul_a;
   logic signed [PW-1:0]     mul_b;
   logic signed [PW-1:0]     prod_next;
   logic signed [SW-1:0]     sum;
   logic                     over_hi;
   logic                     over_lo;
   logic signed [ACC_W-1:0]  res_next;
   logic                     sat_next;

   // Full-width signed product of the activation and the active weight
   always_comb begin
      mul_a     = PW'(input_data);
      mul_b     = PW'(active_w);
      prod_next = mul_a * mul_b;
   end

   // Accumulate with one guard bit, then either clamp or wrap
   always_comb begin
      sum      = SW'(prod) + SW'(pin);
      over_hi  = sum > SMAX;
      over_lo  = sum < SMIN;
      res_next = sum[ACC_W-1:0];
      sat_next = 1'b0;
      if (clamp_en && over_hi) begin
         res_next = SMAX[ACC_W-1:0];
         sat_next = 1'b1;
      end else if (clamp_en && over_lo) begin
         res_next = SMIN[ACC_W-1:0];
         sat_next = 1'b1;
      end
   end

   // Shadow/active weight pair; swap takes the shadow value before any load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_w <= '0;
         active_w <= '0;
      end else if (enable) begin
         if (load_weight) shadow_w <= weight_data;
         if (swap_weight) active_w <= shadow_w;
      end
   end

   // Stage 1: register product, upstream partial sum and valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod <= '0;
         pin  <= '0;
         v1   <= 1'b0;
      end else if (enable) begin
         prod <= prod_next;
         pin  <= partial_in;
         v1   <= in_valid;
      end
   end

   // Stage 2: result and saturation flag update only on valid slots
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         partial_out <= '0;
         saturated   <= 1'b0;
         out_valid   <= 1'b0;
      end else if (enable) begin
         out_valid <= v1;
         if (v1) begin
            partial_out <= res_next;
            saturated   <= sat_next;
         end
      end
   end

   // Systolic forward of the activation to the neighbouring PE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else if (enable) begin
         data_out_valid <= in_valid;
         if (in_valid) data_out <= input_data;
      end
   end

   // Completed-MAC counter, sticks at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mac_operations <= '0;
      end else if (enable) begin
         if (v1 && (mac_operations != 32'hFFFF_FFFF)) begin
            mac_operations <= mac_operations + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_processing_element.sv
// Scoreboard bench for pipelined_processing_element.
// Directed vectors push hand-computed results; a monitor pops on out_valid.
module tb_pipelined_processing_element;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   logic                     clk;
   logic                     reset;
   logic                     enable;
   logic                     in_valid;
   logic                     load_weight;
   logic                     swap_weight;
   logic                     clamp_en;
   logic signed [DATA_W-1:0] input_data;
   logic signed [DATA_W-1:0] weight_data;
   logic signed [ACC_W-1:0]  partial_in;
   logic signed [DATA_W-1:0] data_out;
   logic                     data_out_valid;
   logic signed [ACC_W-1:0]  partial_out;
   logic                     out_valid;
   logic                     saturated;
   logic [31:0]              mac_operations;

   typedef struct {
      logic signed [ACC_W-1:0] p;
      logic                    s;
      logic [31:0]             m;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_mac = 0;
   logic        en_q = 1'b0;

   pipelined_processing_element #(
      .DATA_W(DATA_W),
      .ACC_W(ACC_W),
      .SAT_MIN(-128),
      .SAT_MAX(127)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .in_valid(in_valid),
      .load_weight(load_weight),
      .swap_weight(swap_weight),
      .clamp_en(clamp_en),
      .input_data(input_data),
      .weight_data(weight_data),
      .partial_in(partial_in),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .partial_out(partial_out),
      .out_valid(out_valid),
      .saturated(saturated),
      .mac_operations(mac_operations)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name,
                  $signed(act), $signed(exp));
      end
   endtask

   // Remember whether the last rising edge was an enabled one
   always @(posedge clk) en_q <= enable;

   // Monitor: every fresh result is matched against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (!reset && en_q && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got partial_out %0d expected no result",
                     partial_out);
         end else begin
            e = sb.pop_front();
            chk("partial_out", 64'(partial_out), 64'(e.p));
            chk("saturated", 64'(saturated), 64'(e.s));
            chk("mac_operations", 64'(mac_operations), 64'(e.m));
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_w(input logic signed [DATA_W-1:0] w);
      load_weight = 1'b1;
      weight_data = w;
      step();
      load_weight = 1'b0;
   endtask

   task automatic swap_w();
      swap_weight = 1'b1;
      step();
      swap_weight = 1'b0;
   endtask

   task automatic issue(input logic signed [DATA_W-1:0] x,
                        input logic signed [ACC_W-1:0] p,
                        input logic signed [ACC_W-1:0] ep,
                        input logic es);
      exp_t e;
      exp_mac    = exp_mac + 1;
      e.p        = ep;
      e.s        = es;
      e.m        = exp_mac;
      sb.push_back(e);
      enable     = 1'b1;
      in_valid   = 1'b1;
      input_data = x;
      partial_in = p;
      step();
      in_valid   = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_partial_out"}, 64'(partial_out), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_saturated"}, 64'(saturated), 64'd0);
      chk({tag, "_data_out"}, 64'(data_out), 64'd0);
      chk({tag, "_data_out_valid"}, 64'(data_out_valid), 64'd0);
      chk({tag, "_mac_operations"}, 64'(mac_operations), 64'd0);
   endtask

   initial begin
      reset       = 1'b1;
      enable      = 1'b0;
      in_valid    = 1'b0;
      load_weight = 1'b0;
      swap_weight = 1'b0;
      clamp_en    = 1'b1;
      input_data  = '0;
      weight_data = '0;
      partial_in  = '0;

      repeat (3) step();
      chk_all_zero("reset");
      reset  = 1'b0;
      enable = 1'b1;
      step();

      // Basic MAC: 3 * 2 + 0
      load_w(16'sd3);
      swap_w();
      issue(16'sd2, 32'sd0, 32'sd6, 1'b0);
      step();

      // Double buffer: load 7 without swap, then load 9 with swap
      load_w(16'sd7);
      issue(16'sd2, 32'sd0, 32'sd6, 1'b0);
      load_weight = 1'b1;
      swap_weight = 1'b1;
      weight_data = 16'sd9;
      step();
      load_weight = 1'b0;
      swap_weight = 1'b0;
      issue(16'sd2, 32'sd0, 32'sd14, 1'b0);
      swap_w();
      issue(16'sd2, 32'sd0, 32'sd18, 1'b0);
      step();

      // Clamp high, clamp low, then wrap mode
      clamp_en = 1'b1;
      load_w(16'sd100);
      swap_w();
      issue(16'sd2, 32'sd10000, 32'sd127, 1'b1);
      load_w(-16'sd100);
      swap_w();
      issue(16'sd2, -32'sd10000, -32'sd128, 1'b1);
      load_w(16'sd100);
      swap_w();
      clamp_en = 1'b0;
      issue(16'sd2, 32'sd10000, 32'sd10200, 1'b0);
      step();

      // clamp_en is taken at the completing edge, not at issue
      clamp_en = 1'b1;
      issue(16'sd2, 32'sd10000, 32'sd10200, 1'b0);
      clamp_en = 1'b0;
      step();
      issue(16'sd2, 32'sd10000, 32'sd127, 1'b1);
      clamp_en = 1'b1;
      step();

      // Stall in the middle of three back-to-back issues
      clamp_en = 1'b0;
      issue(16'sd1, 32'sd0, 32'sd100, 1'b0);
      enable     = 1'b0;
      in_valid   = 1'b1;
      input_data = 16'sd9;
      step();
      chk("stall_out_valid", 64'(out_valid), 64'd0);
      chk("stall_partial_hold", 64'(partial_out), 64'(32'sd127));
      chk("stall_data_out_hold", 64'(data_out), 64'(16'sd1));
      issue(16'sd2, 32'sd0, 32'sd200, 1'b0);
      issue(16'sd3, 32'sd5, 32'sd305, 1'b0);
      step();
      step();
      chk("bubble_out_valid", 64'(out_valid), 64'd0);
      chk("bubble_partial_hold", 64'(partial_out), 64'(32'sd305));

      // Reset while an operation is in flight
      in_valid   = 1'b1;
      input_data = 16'sd4;
      partial_in = 32'sd1;
      step();
      in_valid = 1'b0;
      #1 reset = 1'b1;
      #1 chk_all_zero("midreset");
      sb.delete();
      exp_mac = 0;
      #1 reset = 1'b0;
      step();
      step();
      step();
      chk("post_reset_out_valid", 64'(out_valid), 64'd0);
      chk("post_reset_mac", 64'(mac_operations), 64'd0);

      // Forwarding on the first issue after reset (weights are now 0)
      issue(16'sd5, 32'sd0, 32'sd0, 1'b0);
      chk("fwd_data_out", 64'(data_out), 64'(16'sd5));
      chk("fwd_data_out_valid", 64'(data_out_valid), 64'd1);
      step();
      chk("fwd_hold_data_out", 64'(data_out), 64'(16'sd5));
      chk("fwd_hold_valid", 64'(data_out_valid), 64'd0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending results expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
